// File: rtl/reg_hex_dump.sv
// Register-bus hex dumper: reads consecutive device registers and
// prints them as uppercase hex lines through a polled UART port.
module reg_hex_dump #(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 8,
  parameter int CNT_W       = 8,
  parameter int PER_LINE    = 4,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [CNT_W-1:0]  i_count,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic              o_dev_en,
  output logic              o_dev_wr,
  output logic [ADDR_W-1:0] o_dev_addr,
  input  logic              i_dev_ack,
  input  logic [DATA_W-1:0] i_dev_data,
  output logic              o_uart_en,
  output logic              o_uart_wr,
  output logic [3:0]        o_uart_addr,
  output logic [7:0]        o_uart_wdata,
  input  logic [7:0]        i_uart_rdata
);

  localparam int AD   = (ADDR_W + 3) / 4;
  localparam int DD   = DATA_W / 4;
  localparam int CMAX = (AD > DD) ? AD : DD;
  localparam int CI_W = $clog2(CMAX + 2);
  localparam int LN_W = (PER_LINE > 1) ? $clog2(PER_LINE) : 1;
  localparam int TO_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_RD, S_POLL, S_PDROP, S_PCHK,
    S_SEND, S_SEND_END, S_DONE
  } state_t;

  typedef enum logic [1:0] {
    PH_HDR, PH_ITEM, PH_EOL
  } phase_t;

  state_t            r_state;
  state_t            w_nxt;
  phase_t            r_ph;
  logic [CI_W-1:0]   r_ci;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_line_addr;
  logic [CNT_W-1:0]  r_rem;
  logic [LN_W-1:0]   r_ln;
  logic [TO_W-1:0]   r_tmo;
  logic [DATA_W-1:0] r_data;
  logic              r_to;
  logic              r_err;

  logic              r_busy, r_done, r_dev_en;
  logic              r_uart_en, r_uart_wr;
  logic [3:0]        r_uart_addr;
  logic [7:0]        r_uart_wdata;

  logic              w_busy, w_done, w_dev_en;
  logic              w_uart_en, w_uart_wr;
  logic [3:0]        w_uart_addr;
  logic [7:0]        w_uart_wdata;
  logic [7:0]        w_char;
  logic              w_plast;
  logic              w_last;
  logic              w_full;
  logic              w_tmo_hit;
  logic [AD*4-1:0]   w_apad;

  function automatic logic [7:0] hex(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n}
                       : 8'h37 + {4'h0, n};
  endfunction

  assign w_apad    = (AD*4)'(r_line_addr);
  assign w_last    = (r_rem == CNT_W'(1));
  assign w_full    = (r_ln == LN_W'(PER_LINE - 1));
  assign w_tmo_hit = (r_tmo == TO_W'(ACK_TIMEOUT - 1));

  always_comb begin
    w_char  = 8'h00;
    w_plast = 1'b0;
    unique case (r_ph)
      PH_HDR: begin
        w_plast = (r_ci == CI_W'(AD));
        if (w_plast) w_char = 8'h3A;
        else w_char = hex(4'(w_apad >> (4*(AD-1-int'(r_ci)))));
      end
      PH_ITEM: begin
        w_plast = (r_ci == CI_W'(DD));
        if (r_ci == '0) w_char = 8'h20;
        else if (r_to) w_char = 8'h3F;
        else w_char = hex(4'(r_data >> (4*(DD-int'(r_ci)))));
      end
      PH_EOL: begin
        w_plast = (r_ci == CI_W'(1));
        w_char  = (r_ci == '0) ? 8'h0D : 8'h0A;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE:
        if (i_start)
          w_nxt = (i_count == '0) ? S_DONE : S_POLL;
      S_RD:
        if (i_dev_ack || w_tmo_hit) w_nxt = S_POLL;
      S_POLL:  w_nxt = S_PDROP;
      S_PDROP: w_nxt = S_PCHK;
      S_PCHK:
        w_nxt = (i_uart_rdata != 8'h00) ? S_SEND : S_POLL;
      S_SEND:  w_nxt = S_SEND_END;
      S_SEND_END: begin
        if (!w_plast) w_nxt = S_POLL;
        else unique case (1'b1)
          (r_ph == PH_HDR):  w_nxt = S_RD;
          (r_ph == PH_ITEM):
            w_nxt = (w_last || w_full) ? S_POLL : S_RD;
          default:
            w_nxt = (r_rem == '0) ? S_DONE : S_POLL;
        endcase
      end
      S_DONE:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase

    w_busy       = (w_nxt != S_IDLE) && (w_nxt != S_DONE);
    w_done       = (w_nxt == S_DONE);
    w_dev_en     = (w_nxt == S_RD);
    w_uart_en    = (w_nxt == S_POLL) || (w_nxt == S_SEND);
    w_uart_wr    = (w_nxt == S_SEND);
    w_uart_addr  = (w_nxt == S_SEND) ? 4'h1 : 4'h0;
    w_uart_wdata = (w_nxt == S_SEND) ? w_char : 8'h00;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_ph         <= PH_HDR;
      r_ci         <= '0;
      r_addr       <= '0;
      r_line_addr  <= '0;
      r_rem        <= '0;
      r_ln         <= '0;
      r_tmo        <= '0;
      r_data       <= '0;
      r_to         <= 1'b0;
      r_err        <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_dev_en     <= 1'b0;
      r_uart_en    <= 1'b0;
      r_uart_wr    <= 1'b0;
      r_uart_addr  <= 4'h0;
      r_uart_wdata <= 8'h00;
    end else begin
      r_busy       <= w_busy;
      r_done       <= w_done;
      r_dev_en     <= w_dev_en;
      r_uart_en    <= w_uart_en;
      r_uart_wr    <= w_uart_wr;
      r_uart_addr  <= w_uart_addr;
      r_uart_wdata <= w_uart_wdata;
      r_tmo        <= '0;
      unique case (r_state)
        S_IDLE:
          if (i_start) begin
            r_addr      <= i_base_addr;
            r_line_addr <= i_base_addr;
            r_rem       <= i_count;
            r_ln        <= '0;
            r_ph        <= PH_HDR;
            r_ci        <= '0;
            r_err       <= 1'b0;
          end
        S_RD: begin
          r_tmo <= r_tmo + TO_W'(1);
          if (i_dev_ack) begin
            r_data <= i_dev_data;
            r_to   <= 1'b0;
          end else if (w_tmo_hit) begin
            r_to  <= 1'b1;
            r_err <= 1'b1;
          end
          if (i_dev_ack || w_tmo_hit) begin
            r_ph <= PH_ITEM;
            r_ci <= '0;
          end
        end
        S_SEND_END: begin
          if (!w_plast) r_ci <= r_ci + CI_W'(1);
          else begin
            r_ci <= '0;
            if (r_ph == PH_ITEM) begin
              r_rem  <= r_rem - CNT_W'(1);
              r_addr <= r_addr + ADDR_W'(1);
              r_ln   <= r_ln + LN_W'(1);
              if (w_last || w_full) r_ph <= PH_EOL;
            end else if (r_ph == PH_EOL) begin
              r_ph        <= PH_HDR;
              r_line_addr <= r_addr;
              r_ln        <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_err        = r_err;
  assign o_dev_en     = r_dev_en;
  assign o_dev_wr     = 1'b0;
  assign o_dev_addr   = r_addr;
  assign o_uart_en    = r_uart_en;
  assign o_uart_wr    = r_uart_wr;
  assign o_uart_addr  = r_uart_addr;
  assign o_uart_wdata = r_uart_wdata;

endmodule

// File: tb/tb_reg_hex_dump.sv
// Directed bench for reg_hex_dump with device and UART responders.
module tb_reg_hex_dump;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_start;
  logic [3:0] i_base;
  logic [7:0] i_count;
  logic       o_busy, o_done, o_err;
  logic       o_dev_en, o_dev_wr;
  logic [3:0] o_dev_addr;
  logic       i_dev_ack;
  logic [7:0] i_dev_data;
  logic       o_uart_en, o_uart_wr;
  logic [3:0] o_uart_addr;
  logic [7:0] o_uart_wdata;
  logic [7:0] i_uart_rdata;

  int checks = 0;
  int errors = 0;

  logic [7:0] q[$];
  int dcnt, noack_g, stall_g, npoll;
  int n_done, n_dev, n_uart, n_poll, n_wr;
  int n_na, n_both, n_badwr;
  bit rdy;

  localparam string EXP1 = "E: EE FF 00 11\r\n2: 22\r\n";
  localparam string EXP3 = "2: 22 ?? 44\r\n";

  always #5 clk = ~clk;

  reg_hex_dump dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start),
    .i_base_addr(i_base), .i_count(i_count),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .o_dev_en(o_dev_en), .o_dev_wr(o_dev_wr),
    .o_dev_addr(o_dev_addr), .i_dev_ack(i_dev_ack),
    .i_dev_data(i_dev_data),
    .o_uart_en(o_uart_en), .o_uart_wr(o_uart_wr),
    .o_uart_addr(o_uart_addr), .o_uart_wdata(o_uart_wdata),
    .i_uart_rdata(i_uart_rdata)
  );

  wire [22:0] outs = {o_busy, o_done, o_err, o_dev_en, o_dev_wr,
                      o_dev_addr, o_uart_en, o_uart_wr,
                      o_uart_addr, o_uart_wdata};

  task automatic chk(input string tag, input longint got,
                     input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // device: ack two cycles after en, except at the stuck address
  always @(negedge clk) begin
    if (o_dev_en) begin
      dcnt++;
      n_dev++;
      if (int'(o_dev_addr) == noack_g) n_na++;
      if (dcnt >= 2 && int'(o_dev_addr) != noack_g) begin
        i_dev_ack  = 1'b1;
        i_dev_data = {o_dev_addr, o_dev_addr};
      end
    end else begin
      dcnt      = 0;
      i_dev_ack = 1'b0;
    end
    if (o_dev_en && o_uart_en) n_both++;
    if (o_done) n_done++;
    if (o_uart_en) n_uart++;
  end

  always @(negedge clk) begin
    if (o_uart_en && !o_uart_wr && o_uart_addr == 4'h0) begin
      npoll++;
      n_poll++;
      rdy = (npoll > stall_g);
      i_uart_rdata = rdy ? 8'h01 : 8'h00;
    end
    if (o_uart_en && o_uart_wr && o_uart_addr == 4'h1) begin
      q.push_back(o_uart_wdata);
      n_wr++;
      if (!rdy) n_badwr++;
      rdy   = 1'b0;
      npoll = 0;
    end
  end

  function automatic int nbad(input string e);
    int b = 0;
    for (int i = 0; i < e.len(); i++)
      if (i >= q.size() || q[i] != e[i]) b++;
    return b;
  endfunction

  task automatic clr();
    q.delete();
    n_done = 0; n_dev = 0; n_uart = 0; n_poll = 0;
    n_wr = 0; n_na = 0; n_both = 0; n_badwr = 0;
    npoll = 0; rdy = 1'b0;
  endtask

  task automatic run(input string tag, input logic [3:0] base,
                     input logic [7:0] cnt, input int stall,
                     input int noack, input bit dup,
                     input bit errclr, input string exp);
    int k;
    clr();
    stall_g = stall;
    noack_g = noack;
    @(negedge clk);
    i_base = base; i_count = cnt; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    if (errclr) chk({tag, "_errclr"}, o_err, 0);
    chk({tag, "_busy"}, o_busy, 1);
    if (dup) begin
      repeat (30) @(negedge clk);
      i_base = 4'h0; i_count = 8'd1; i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
    end
    k = 0;
    while (!o_done && k < 20000) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_done"}, o_done, 1);
    chk({tag, "_busy_at_done"}, o_busy, 0);
    repeat (10) @(negedge clk);
    chk({tag, "_ndone"}, n_done, 1);
    chk({tag, "_idle"}, o_busy, 0);
    chk({tag, "_len"}, q.size(), exp.len());
    chk({tag, "_bytes"}, nbad(exp), 0);
    chk({tag, "_nwr"}, n_wr, exp.len());
    chk({tag, "_badwr"}, n_badwr, 0);
    chk({tag, "_excl"}, n_both, 0);
  endtask

  task automatic wait_for(input string tag, input int what);
    int k = 0;
    while (k < 2000 && !((what == 0) ? o_dev_en
                                     : (o_uart_en && o_uart_wr))) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_reached"}, k < 2000, 1);
  endtask

  task automatic mid_reset(input string tag, input int what);
    clr();
    stall_g = 0;
    noack_g = -1;
    @(negedge clk);
    i_base = 4'hE; i_count = 8'd5; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    wait_for(tag, what);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk({tag, "_outs0"}, outs, 0);
    clr();
    repeat (5) @(negedge clk);
    chk({tag, "_quiet"}, n_dev + n_uart, 0);
    chk({tag, "_outs_idle"}, outs, 0);
  endtask

  initial begin
    rst_n = 1'b0; i_start = 1'b0; i_base = '0; i_count = '0;
    i_dev_ack = 1'b0; i_dev_data = '0; i_uart_rdata = '0;
    dcnt = 0; noack_g = -1; stall_g = 0;
    clr();
    repeat (3) @(negedge clk);
    chk("reset_outs", outs, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_idle", outs, 0);

    run("t1", 4'hE, 8'd5, 0, -1, 1'b0, 1'b0, EXP1);
    chk("t1_err", o_err, 0);
    chk("t1_polls", n_poll, EXP1.len());

    clr();
    @(negedge clk);
    i_base = 4'h5; i_count = 8'd0; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    chk("t2_done", o_done, 1);
    repeat (5) @(negedge clk);
    chk("t2_ndone", n_done, 1);
    chk("t2_dev", n_dev, 0);
    chk("t2_uart", n_uart, 0);

    run("t3", 4'h2, 8'd3, 0, 3, 1'b0, 1'b0, EXP3);
    chk("t3_na_cycles", n_na, 15);
    chk("t3_err", o_err, 1);

    run("t4", 4'hE, 8'd5, 20, -1, 1'b0, 1'b1, EXP1);
    chk("t4_polls", n_poll, 21 * EXP1.len());
    chk("t4_err", o_err, 0);

    mid_reset("t5rd", 0);
    mid_reset("t5snd", 1);
    run("t5", 4'hE, 8'd5, 0, -1, 1'b0, 1'b0, EXP1);

    run("t6", 4'hE, 8'd5, 0, -1, 1'b1, 1'b0, EXP1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
